gf64_pow_sbox_engine: RTL and testbench
=======================================

# gf64_pow_sbox_engine

Multi-cycle 6-bit S-box engine. Per lane it computes p = x^E in GF(2^6) for an exponent E supplied at run time, then applies the output affine step: every bit of p is XORed with t = parity(x & TMASK). It generalises the fixed-exponent combinational power-map S-boxes to a runtime exponent, LANES parallel lanes and valid/ready handshakes. It sits between the data-path register stage and the S-box evaluation harness.

## Interface
Parameters:
- LANES, 1: number of parallel 6-bit lanes; all lanes share the exponent and the handshake.
- TMASK, 6'b010100: input-bit mask for the affine parity t; 0 disables the affine step.

Ports:
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  engine can accept a request.
- x  input  6*LANES  operands; lane i is x[6i+5:6i], bit 0 is the constant term.
- e  input  6  exponent E, 0..63.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- y  output  6*LANES  results; lane i is y[6i+5:6i].

## Operation
- Field: GF(2^6) in polynomial basis, reduction polynomial z^6+z+1.
- Multiply: carry-less 6x6 product to 11 bits, reduced with z^6 = z+1. Square uses the same reduction.
- Conventions: x^0 = 1 for every x, including x = 0. 0^E = 0 for E > 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid & in_ready: latch x into base regs, e into exp reg, set acc = 6'h01 per lane, clear the 3-bit counter, go to RUN.
- RUN: one iteration per cycle, exponent bit e[5-cnt] taken MSB first.
  - acc <= e[5-cnt] ? (acc^2)*base : acc^2.
  - cnt increments each cycle. After the cnt = 5 iteration, go to DONE.
- DONE:
  - out_valid = 1.
  - Per lane, y = acc ^ {6{t}}, where t = ^(base & TMASK) uses the latched x.
  - On out_ready, go to IDLE.
  - No back-to-back acceptance: in_ready is 0 in RUN and in DONE, including the DONE handshake cycle.
- Inputs x and e are sampled only at acceptance. Later changes have no effect on the operation in progress.
- in_valid while not ready is ignored and not queued.
- Reset (asynchronous, any state, including mid-RUN): state = IDLE, acc/base/exp/cnt = 0, out_valid = 0, y = 0. The in-flight operation is discarded.
- in_ready is forced to 0 while rst_n is low. It rises in the first cycle after release.

## Timing
- Reset values: in_ready = 0 (during reset), out_valid = 0, y = 0.
- Acceptance at rising edge k.
- RUN iterations at edges k+1 .. k+6.
- out_valid is high after edge k+6: latency 6 cycles from accept to out_valid.
- With out_ready held high: result handshake at edge k+7, in_ready high after k+7, next accept at k+8 at the earliest. Peak throughput is one request per 8 cycles.
- Backpressure: while out_valid & !out_ready, y, out_valid and state hold unchanged for any number of cycles.
- y is registered-equivalent: a function of state registers only, with no combinational path from x, e or out_ready.
- in_ready depends only on state and rst_n.
- One square-multiply per cycle is the critical path. No multicycle paths.

## Test plan
- Single-lane basic, LANES=1, default TMASK:
  - x=6'h02, e=6 -> y=6'h03 (α^6=α+1, t=0), out_valid 6 cycles after accept.
  - x=6'h04, e=3 -> y=6'h3C (p=6'h03, t=1).
- Zero and exponent boundaries:
  - x=6'h00, e=0 -> y=6'h01.
  - x=6'h00, e=5 -> y=6'h00.
  - x=6'h15, e=63 -> y=6'h01.
  - x=6'h02, e=62 -> y=6'h21 (inverse of α).
  - TMASK=0, x=6'h04, e=3 -> y=6'h03.
- Multi-lane, LANES=2:
  - x={6'h04,6'h02}, e=6 -> y={6'h3A,6'h03}.
  - Lane 1: α^12 = 6'h05, t=1 -> 6'h3A.
- Backpressure:
  - out_ready held low 5 cycles after out_valid -> y stable, in_ready=0.
  - A new in_valid with different x during this window is ignored.
  - The next request is accepted only after the out handshake plus one cycle.
- Input isolation: change x and e every cycle during RUN -> result equals the value computed from the operands sampled at acceptance.
- Reset mid-RUN: assert rst_n low at edge k+3 of an operation.
  - out_valid=0 and y=0 immediately (asynchronous); no result is produced.
  - After release, a fresh request x=6'h02, e=1 -> y=6'h02.

Source files
------------

// File: rtl/gf64_pow_sbox_engine_if.sv
// Request/result bus of the GF(2^6) power-map S-box engine.
// Handshakes: a transfer happens on a rising edge where valid & ready are both high; valid never waits on ready.
interface gf64_pow_sbox_engine_if #(
    parameter int LANES = 1
);
    logic                 in_valid;
    logic                 in_ready;
    logic [6*LANES-1:0]   x;
    logic [5:0]           e;
    logic                 out_valid;
    logic                 out_ready;
    logic [6*LANES-1:0]   y;

    modport master (
        output in_valid, x, e, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, x, e, out_ready,
        output in_ready, out_valid, y
    );
endinterface

// File: rtl/gf64_pow_sbox_engine.sv
// Runtime-exponent GF(2^6) power map (poly z^6+z+1) with output affine parity, MSB-first square-multiply.
// One square and one optional multiply per cycle; six iterations per request.
module gf64_pow_sbox_engine #(
    parameter int         LANES = 1,
    parameter logic [5:0] TMASK = 6'b010100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    gf64_pow_sbox_engine_if.slave bus,
    output logic [1:0]            o_dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]           r_state;
    logic [2:0]           r_cnt;
    logic [5:0]           r_exp;
    logic [6*LANES-1:0]   r_base;
    logic [6*LANES-1:0]   r_acc;
    logic [6*LANES-1:0]   w_acc_next;
    logic [6*LANES-1:0]   w_y;
    logic                 w_bit;

    function automatic logic [5:0] gf_mul(input logic [5:0] a, input logic [5:0] b);
        logic [10:0] p;
        p = '0;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) p = p ^ ({5'b0, a} << i);
        end
        // Fold high terms down with z^6 = z + 1, top bit first.
        for (int k = 10; k >= 6; k--) begin
            if (p[k]) p = p ^ (11'b000_0100_0011 << (k - 6));
        end
        return p[5:0];
    endfunction

    assign w_bit = r_exp[3'd5 - r_cnt];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [5:0] w_sq;
        logic       w_t;
        assign w_sq                = gf_mul(r_acc[6*g +: 6], r_acc[6*g +: 6]);
        assign w_acc_next[6*g +: 6] = w_bit ? gf_mul(w_sq, r_base[6*g +: 6]) : w_sq;
        assign w_t                 = ^(r_base[6*g +: 6] & TMASK);
        assign w_y[6*g +: 6]        = r_acc[6*g +: 6] ^ {6{w_t}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_exp   <= '0;
            r_base  <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_base  <= bus.x;
                        r_exp   <= bus.e;
                        r_acc   <= {LANES{6'h01}};
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd5) r_state <= S_DONE;
                end
                S_DONE: begin
                    if (bus.out_ready) r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // y is gated by state only, so it never follows x, e or out_ready combinationally.
    assign bus.in_ready  = rst_n & (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.y         = (r_state == S_DONE) ? w_y : '0;
    assign o_dbg_state   = r_state;
endmodule

// File: tb/tb_gf64_pow_sbox_engine.sv
// Bench for gf64_pow_sbox_engine: three instances (1 lane, 1 lane with TMASK=0, 2 lanes) share one stimulus stream.
// Expected results come from a repeated-multiplication model of the field.
module tb_gf64_pow_sbox_engine;
    localparam logic [5:0] TM = 6'b010100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [5:0]  e;
    logic [11:0] xv;
    logic [1:0]  dbg_a, dbg_b, dbg_c;
    logic [23:0] ycat;

    int n_tests = 0;
    int n_fail  = 0;
    logic [23:0] exp_q[$];

    always #5 clk = ~clk;

    gf64_pow_sbox_engine_if #(.LANES(1)) bus_a ();
    gf64_pow_sbox_engine_if #(.LANES(1)) bus_b ();
    gf64_pow_sbox_engine_if #(.LANES(2)) bus_c ();

    assign bus_a.in_valid = in_valid;
    assign bus_a.x        = xv[5:0];
    assign bus_a.e        = e;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid = in_valid;
    assign bus_b.x        = xv[5:0];
    assign bus_b.e        = e;
    assign bus_b.out_ready = out_ready;
    assign bus_c.in_valid = in_valid;
    assign bus_c.x        = xv;
    assign bus_c.e        = e;
    assign bus_c.out_ready = out_ready;

    assign ycat = {bus_c.y, bus_b.y, bus_a.y};

    gf64_pow_sbox_engine #(.LANES(1), .TMASK(TM)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .o_dbg_state(dbg_a));
    gf64_pow_sbox_engine #(.LANES(1), .TMASK(6'h00)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .o_dbg_state(dbg_b));
    gf64_pow_sbox_engine #(.LANES(2), .TMASK(TM)) dut_c (
        .clk(clk), .rst_n(rst_n), .bus(bus_c), .o_dbg_state(dbg_c));

    // Reference model: shift-and-add multiply with xtime, power by E repeated multiplications.
    function automatic logic [5:0] ref_mul(input logic [5:0] a, input logic [5:0] b);
        logic [5:0] r;
        logic [5:0] aa;
        r  = 6'h00;
        aa = a;
        for (int i = 0; i < 6; i++) begin
            if (b[i]) r = r ^ aa;
            aa = {aa[4:0], 1'b0} ^ (aa[5] ? 6'h03 : 6'h00);
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_sbox(input logic [5:0] x, input logic [5:0] ee, input logic [5:0] tm);
        logic [5:0] p;
        p = 6'h01;
        for (int i = 0; i < int'(ee); i++) p = ref_mul(p, x);
        return p ^ {6{^(x & tm)}};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic run_op(input logic [5:0] x0, input logic [5:0] x1, input logic [5:0] ee,
                          input int hold, input bit scramble);
        int lat;
        logic [23:0] y_hold;
        @(negedge clk);
        lat = 0;
        while (!bus_a.in_ready && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("in_ready_before_accept", {31'b0, bus_a.in_ready}, 32'd1);
        xv       = {x1, x0};
        e        = ee;
        in_valid = 1'b1;
        exp_q.push_back({ref_sbox(x1, ee, TM), ref_sbox(x0, ee, TM),
                         ref_sbox(x0, ee, 6'h00), ref_sbox(x0, ee, TM)});
        @(negedge clk);
        in_valid = 1'b0;
        check("in_ready_low_in_run", {29'b0, bus_c.in_ready, bus_b.in_ready, bus_a.in_ready}, 32'd0);
        lat = 0;
        while (!bus_a.out_valid && lat < 20) begin
            if (scramble) begin
                xv = 12'($urandom);
                e  = 6'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        check("latency", lat, 32'd6);
        check("out_valid_all", {29'b0, bus_c.out_valid, bus_b.out_valid, bus_a.out_valid}, 32'd7);
        y_hold = ycat;
        for (int h = 0; h < hold; h++) begin
            in_valid = 1'b1;
            xv       = 12'($urandom);
            e        = 6'($urandom);
            @(negedge clk);
            check("hold_y_stable", {8'b0, ycat}, {8'b0, y_hold});
            check("hold_out_valid", {29'b0, bus_c.out_valid, bus_b.out_valid, bus_a.out_valid}, 32'd7);
            check("hold_in_ready_low", {31'b0, bus_a.in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("in_ready_handshake_cycle", {31'b0, bus_a.in_ready}, 32'd0);
        check("result_y", {8'b0, ycat}, {8'b0, exp_q.pop_front()});
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_handshake", {29'b0, bus_c.out_valid, bus_b.out_valid, bus_a.out_valid}, 32'd0);
        check("in_ready_after_handshake", {31'b0, bus_a.in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        e         = 6'h00;
        xv        = 12'h000;
        #1;
        check("reset_in_ready", {31'b0, bus_a.in_ready}, 32'd0);
        check("reset_out_valid", {29'b0, bus_c.out_valid, bus_b.out_valid, bus_a.out_valid}, 32'd0);
        check("reset_y", {8'b0, ycat}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Directed: basic, zero and exponent boundaries, two-lane case in lane 1.
        run_op(6'h02, 6'h04, 6'd6,  0, 1'b0);
        run_op(6'h04, 6'h02, 6'd3,  1, 1'b0);
        run_op(6'h00, 6'h15, 6'd0,  0, 1'b0);
        run_op(6'h00, 6'h3F, 6'd5,  0, 1'b0);
        run_op(6'h15, 6'h00, 6'd63, 0, 1'b0);
        run_op(6'h02, 6'h01, 6'd62, 0, 1'b0);

        // Backpressure for five cycles with ignored requests, then input isolation.
        run_op(6'h2B, 6'h11, 6'd45, 5, 1'b0);
        run_op(6'h1D, 6'h33, 6'd27, 0, 1'b1);

        for (int i = 0; i < 12; i++) begin
            run_op(6'($urandom), 6'($urandom), 6'($urandom),
                   int'($urandom_range(3, 0)), 1'($urandom_range(1, 0)));
        end

        // Reset in the middle of RUN.
        @(negedge clk);
        xv       = {6'h0B, 6'h07};
        e        = 6'h2D;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("midrun_reset_out_valid", {29'b0, bus_c.out_valid, bus_b.out_valid, bus_a.out_valid}, 32'd0);
        check("midrun_reset_y", {8'b0, ycat}, 32'd0);
        check("midrun_reset_in_ready", {29'b0, bus_c.in_ready, bus_b.in_ready, bus_a.in_ready}, 32'd0);
        check("midrun_reset_state", {26'b0, dbg_c, dbg_b, dbg_a}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 3) rst_n = 1'b1;
            check("no_result_after_reset", {29'b0, bus_c.out_valid, bus_b.out_valid, bus_a.out_valid}, 32'd0);
        end
        run_op(6'h02, 6'h02, 6'd1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
